cordic_job_scheduler: RTL and testbench

- Shares one pipelined CORDIC rotator core (xy_size-wide, CORE_LAT-cycle fixed latency, no stall, no internal valid) between two requesters.
- Round-robin arbitration with valid/ready handshakes on the request side; registered drive of the core inputs; a valid/source-tag shift register that tracks jobs in flight.
- Results land in an output FIFO drained by a valid/ready consumer.
- Credit accounting guarantees no result is ever dropped, because the core cannot be back-pressured.

---
 rtl/cordic_job_scheduler.sv | 113 +++++++++++
 tb/tb_cordic_job_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_job_scheduler.sv
// Shares one fixed-latency, non-stallable CORDIC core between two requesters.
// Credits reserve a result FIFO slot at issue time, so the core never needs back-pressure.
module cordic_job_scheduler #(
  parameter int xy_size    = 8,
  parameter int CORE_LAT   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [31:0]        req0_angle,
  input  logic [xy_size-1:0] req0_x,
  input  logic [xy_size-1:0] req0_y,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [31:0]        req1_angle,
  input  logic [xy_size-1:0] req1_x,
  input  logic [xy_size-1:0] req1_y,
  output logic [31:0]        core_angle,
  output logic [xy_size-1:0] core_xin,
  output logic [xy_size-1:0] core_yin,
  input  logic [xy_size-1:0] core_xout,
  input  logic [xy_size-1:0] core_yout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_src,
  output logic [xy_size-1:0] res_x,
  output logic [xy_size-1:0] res_y,
  output logic               busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TAGD = CORE_LAT + 1;
  localparam int EW   = 2 * xy_size + 1;
  localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_fifo_count;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [TAGD-1:0] r_tag_v;
  logic [TAGD-1:0] r_tag_src;
  logic            r_next_pri;

  logic w_can_issue;
  logic w_winner;
  logic w_grant;
  logic w_write;
  logic w_pop;

  // r_next_pri names the requester that wins a contended cycle; it is 0 out of reset.
  always_comb begin
    w_winner    = 1'b0;
    w_can_issue = ({1'b0, r_inflight} + {1'b0, r_fifo_count}) < DEPTH_SUM;
    if (req0_valid && req1_valid) begin
      w_winner = r_next_pri;
    end else if (req1_valid) begin
      w_winner = 1'b1;
    end
    w_grant    = !reset && w_can_issue && (req0_valid || req1_valid);
    req0_ready = w_grant && !w_winner;
    req1_ready = w_grant && w_winner;
  end

  assign w_write   = r_tag_v[TAGD-1];
  assign res_valid = !reset && (r_fifo_count != '0);
  assign w_pop     = res_valid && res_ready;
  assign busy      = !reset && ((r_inflight != '0) || (r_fifo_count != '0));
  assign {res_src, res_x, res_y} = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      core_angle   <= '0;
      core_xin     <= '0;
      core_yin     <= '0;
      r_next_pri   <= 1'b0;
      r_tag_v      <= '0;
      r_tag_src    <= '0;
      r_inflight   <= '0;
      r_fifo_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      if (w_grant) begin
        core_angle <= w_winner ? req1_angle : req0_angle;
        core_xin   <= w_winner ? req1_x     : req0_x;
        core_yin   <= w_winner ? req1_y     : req0_y;
        r_next_pri <= !w_winner;
      end
      r_tag_v      <= {r_tag_v[TAGD-2:0], w_grant};
      r_tag_src    <= {r_tag_src[TAGD-2:0], w_winner};
      r_inflight   <= r_inflight + CW'(w_grant) - CW'(w_write);
      r_fifo_count <= r_fifo_count + CW'(w_write) - CW'(w_pop);
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is left unreset; stale entries are never visible because the count gates them.
  always_ff @(posedge clock) begin
    if (!reset && w_write) begin
      r_mem[r_wr_ptr] <= {r_tag_src[TAGD-1], core_xout, core_yout};
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(w_write && !w_pop && (r_fifo_count == DEPTH_CNT)));

endmodule

// File: tb/tb_cordic_job_scheduler.sv
// Scoreboard bench: a behavioural model predicts grants, credit, latency and result order.
module tb_cordic_job_scheduler;

  localparam int XY    = 8;
  localparam int LAT   = 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [31:0]   req0_angle, req1_angle;
  logic [XY-1:0] req0_x, req0_y, req1_x, req1_y;
  logic [31:0]   core_angle;
  logic [XY-1:0] core_xin, core_yin, core_xout, core_yout;
  logic          res_valid, res_ready, res_src;
  logic [XY-1:0] res_x, res_y;
  logic          busy;

  cordic_job_scheduler #(.xy_size(XY), .CORE_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_angle(req0_angle),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_angle(req1_angle),
    .req1_x(req1_x), .req1_y(req1_y),
    .core_angle(core_angle), .core_xin(core_xin), .core_yin(core_yin),
    .core_xout(core_xout), .core_yout(core_yout),
    .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
    .res_x(res_x), .res_y(res_y), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          src;
    logic [15:0] xy;
    int          hs;
  } exp_t;

  exp_t sb[$];
  int   grantLog[$];
  int   tests = 0;
  int   errors = 0;
  int   cyc = 0;
  int   outstanding = 0;
  int   lastGrant = 1;
  bit   hs0 = 0, hs1 = 0, prevReset = 0;

  // Stand-in core: arbitrary recognisable transform, LAT cycles after the inputs are seen.
  function automatic logic [15:0] coreXform(input logic [31:0] a, input logic [7:0] x,
                                             input logic [7:0] y);
    logic [7:0] nx, ny;
    nx = x + a[31:24];
    ny = y ^ a[15:8] ^ {x[3:0], x[7:4]};
    return {nx, ny};
  endfunction

  logic [15:0] corePipe [LAT];
  always @(posedge clock) begin
    corePipe[0] <= coreXform(core_angle, core_xin, core_yin);
    for (int i = 1; i < LAT; i++) corePipe[i] <= corePipe[i-1];
  end
  assign {core_xout, core_yout} = corePipe[LAT-1];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: model checks at the falling edge, then scoreboard push/pop.
  initial begin
    bit expBusy, expValid, canIssue, expR0, expR1, popped;
    forever begin
      @(negedge clock);
      if (reset) begin
        checkOutput("reset_req0_ready", 32'(req0_ready), 0);
        checkOutput("reset_req1_ready", 32'(req1_ready), 0);
        checkOutput("reset_res_valid", 32'(res_valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        sb.delete();
        outstanding = 0;
        lastGrant = 1;
        hs0 = 0;
        hs1 = 0;
        prevReset = 1;
      end else begin
        if (prevReset) begin
          checkOutput("reset_core_angle", core_angle, 0);
          checkOutput("reset_core_xy", 32'({core_xin, core_yin}), 0);
        end
        prevReset = 0;
        expBusy  = sb.size() != 0;
        expValid = (sb.size() != 0) && (sb[0].hs + LAT + 2 <= cyc);
        canIssue = outstanding < DEPTH;
        expR0 = canIssue && req0_valid && (!req1_valid || lastGrant == 1);
        expR1 = canIssue && req1_valid && (!req0_valid || lastGrant == 0);
        checkOutput("req0_ready", 32'(req0_ready), 32'(expR0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(expR1));
        checkOutput("res_valid", 32'(res_valid), 32'(expValid));
        checkOutput("busy", 32'(busy), 32'(expBusy));
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        popped = 0;
        if (res_valid && res_ready) begin
          checkOutput("result_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            checkOutput("result", 32'({res_src, res_x, res_y}), 32'({sb[0].src, sb[0].xy}));
            void'(sb.pop_front());
            popped = 1;
          end
        end
        if (hs0) begin
          sb.push_back('{0, coreXform(req0_angle, req0_x, req0_y), cyc});
          grantLog.push_back(0);
          lastGrant = 0;
        end
        if (hs1) begin
          sb.push_back('{1, coreXform(req1_angle, req1_x, req1_y), cyc});
          grantLog.push_back(1);
          lastGrant = 1;
        end
        outstanding = outstanding + int'(hs0) + int'(hs1) - int'(popped);
      end
    end
  end

  // One cycle of stimulus; operands are refreshed only once the previous job was taken.
  task automatic applyStimulus(input bit want0, input bit want1, input bit rr);
    @(posedge clock);
    #1;
    if (hs0 || !req0_valid) begin
      req0_angle = $urandom();
      req0_x = XY'($urandom());
      req0_y = XY'($urandom());
    end
    if (hs1 || !req1_valid) begin
      req1_angle = $urandom();
      req1_x = XY'($urandom());
      req1_y = XY'($urandom());
    end
    req0_valid = want0;
    req1_valid = want1;
    res_ready = rr;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 0, 1);
      if (sb.size() == 0 && !busy) break;
    end
    checkOutput("drain_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit done;
    reset = 1;
    req0_valid = 0; req1_valid = 0; res_ready = 0;
    req0_angle = 0; req0_x = 0; req0_y = 0;
    req1_angle = 0; req1_x = 0; req1_y = 0;
    repeat (3) @(posedge clock);
    #1 reset = 0;

    // Single directed job, then check the registered core drive
    @(posedge clock);
    #1;
    req0_valid = 1; req0_angle = 32'h2000_0000; req0_x = 8'd64; req0_y = 8'd0; res_ready = 1;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(posedge clock);
      #1;
      if (hs0) done = 1;
    end
    req0_valid = 0;
    checkOutput("single_handshake", 32'(done), 1);
    checkOutput("single_core_angle", core_angle, 32'h2000_0000);
    checkOutput("single_core_xy", 32'({core_xin, core_yin}), 32'({8'd64, 8'd0}));
    drain();

    // Both requesters held valid: one grant per cycle, alternating
    grantLog.delete();
    repeat (20) applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 1);
    checkOutput("alt_grant_count", 32'(grantLog.size()), 20);
    for (int i = 1; i < grantLog.size(); i++)
      checkOutput("alt_order", 32'(grantLog[i]), 32'(1 - grantLog[i-1]));
    drain();

    // Consumer stalled: credit stops issue at DEPTH, then one pop while full
    grantLog.delete();
    repeat (40) applyStimulus(1, 0, 0);
    checkOutput("credit_limit", 32'(grantLog.size()), DEPTH);
    applyStimulus(1, 0, 1);
    repeat (15) applyStimulus(1, 0, 0);
    checkOutput("credit_after_pop", 32'(grantLog.size()), DEPTH + 1);
    drain();

    // Reset with six jobs in flight and three buffered
    repeat (3) applyStimulus(1, 0, 0);
    repeat (7) applyStimulus(0, 0, 0);
    repeat (6) applyStimulus(1, 0, 0);
    @(posedge clock);
    #1;
    checkOutput("pre_reset_jobs", 32'(sb.size()), 9);
    reset = 1; req0_valid = 0;
    @(posedge clock);
    #1 reset = 0;
    repeat (LAT + 2) applyStimulus(0, 0, 1);

    // Randomized traffic and consumer stalls
    repeat (400) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               $urandom_range(0, 3) != 0);
    drain();

    // Only req1 for three cycles, then contention goes to req0
    grantLog.delete();
    repeat (3) applyStimulus(0, 1, 1);
    repeat (2) applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 1);
    checkOutput("rr_count", 32'(grantLog.size()), 5);
    if (grantLog.size() == 5) begin
      for (int i = 0; i < 3; i++) checkOutput("rr_req1_only", 32'(grantLog[i]), 1);
      checkOutput("rr_first_contended", 32'(grantLog[3]), 0);
      checkOutput("rr_second_contended", 32'(grantLog[4]), 1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
